// File: rtl/aib_link_seq_if.sv
// Bundle of the start/enable controls, far-side status inputs and
// near-side/status outputs of the AIB link bring-up sequencer.
// master: register block / channel-array side. slave: the sequencer.
interface aib_link_seq_if #(
  parameter int NumChannels = 6
);
  logic                   i_start;
  logic [NumChannels-1:0] i_chn_en;
  logic [NumChannels-1:0] i_fs_adapter_rstn;
  logic [NumChannels-1:0] i_fs_mac_rdy;
  logic [NumChannels-1:0] i_word_aligned;
  logic [NumChannels-1:0] o_ns_adapter_rstn;
  logic [NumChannels-1:0] o_ns_mac_rdy;
  logic                   o_conf_done;
  logic                   o_busy;
  logic                   o_error;
  logic [NumChannels-1:0] o_fail_mask;
  logic [2:0]             o_state;

  modport master (
    output i_start, i_chn_en, i_fs_adapter_rstn, i_fs_mac_rdy, i_word_aligned,
    input  o_ns_adapter_rstn, o_ns_mac_rdy, o_conf_done, o_busy, o_error,
           o_fail_mask, o_state
  );

  modport slave (
    input  i_start, i_chn_en, i_fs_adapter_rstn, i_fs_mac_rdy, i_word_aligned,
    output o_ns_adapter_rstn, o_ns_mac_rdy, o_conf_done, o_busy, o_error,
           o_fail_mask, o_state
  );
endinterface

// File: rtl/aib_link_seq.sv
// Per-channel AIB link bring-up sequencer. Holds near-side adapter reset,
// releases it, raises MAC-ready, and waits for the far side and word
// alignment in each phase under a shared timeout. Watches the link while
// up and reports failing channels.
// Optional feature: define AIB_LINK_SEQ_SYNC_EN to pass the far-side
// status inputs through 2-flop synchronizers (2 cycles of extra latency).
module aib_link_seq #(
  parameter int NumChannels   = 6,
  parameter int WaitCycles    = 64,
  parameter int TimeoutCycles = 4096
) (
  input logic          i_clk,
  input logic          i_rst_n,
  aib_link_seq_if.slave bus
);

  localparam int MaxCycles = (WaitCycles > TimeoutCycles) ? WaitCycles : TimeoutCycles;
  localparam int CntW      = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] WaitLast    = CntW'(WaitCycles - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TimeoutCycles - 1);
  localparam logic [CntW-1:0] CntMax      = '1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RST_WAIT = 3'd1,
    ADP_REL  = 3'd2,
    MAC_RDY  = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic [NumChannels-1:0] en_q, en_d;
  logic [CntW-1:0]        cnt_q;
  logic                   cnt_clr;
  logic [NumChannels-1:0] ns_rstn_q, ns_rstn_d;
  logic [NumChannels-1:0] ns_mac_q, ns_mac_d;
  logic [NumChannels-1:0] fail_q, fail_d;
  logic                   conf_done_q, conf_done_d;
  logic                   error_q, error_d;
  logic                   busy_q, busy_d;
  logic                   start_ok;

  logic [NumChannels-1:0] fs_rstn;
  logic [NumChannels-1:0] fs_mac;
  logic [NumChannels-1:0] fs_aln;

`ifdef AIB_LINK_SEQ_SYNC_EN
  logic [NumChannels-1:0] fs_rstn_p0, fs_rstn_p1;
  logic [NumChannels-1:0] fs_mac_p0, fs_mac_p1;
  logic [NumChannels-1:0] fs_aln_p0, fs_aln_p1;

  // Two-flop synchronizers for the far-side status inputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fs_rstn_p0 <= '0;
      fs_rstn_p1 <= '0;
      fs_mac_p0  <= '0;
      fs_mac_p1  <= '0;
      fs_aln_p0  <= '0;
      fs_aln_p1  <= '0;
    end else begin
      // stage p0: first capture of the asynchronous inputs
      fs_rstn_p0 <= bus.i_fs_adapter_rstn;
      fs_mac_p0  <= bus.i_fs_mac_rdy;
      fs_aln_p0  <= bus.i_word_aligned;
      // stage p1: settled values used by the sequencer
      fs_rstn_p1 <= fs_rstn_p0;
      fs_mac_p1  <= fs_mac_p0;
      fs_aln_p1  <= fs_aln_p0;
    end
  end

  assign fs_rstn = fs_rstn_p1;
  assign fs_mac  = fs_mac_p1;
  assign fs_aln  = fs_aln_p1;
`else
  assign fs_rstn = bus.i_fs_adapter_rstn;
  assign fs_mac  = bus.i_fs_mac_rdy;
  assign fs_aln  = bus.i_word_aligned;
`endif

  assign start_ok = bus.i_start &&
                    (state_q == IDLE || state_q == DONE || state_q == ERROR);

  // Next-state and next-output logic; a start request overrides any phase decision
  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    cnt_clr   = 1'b0;
    ns_rstn_d = ns_rstn_q;
    ns_mac_d  = ns_mac_q;
    fail_d    = fail_q;

    case (state_q)
      IDLE: ;
      RST_WAIT: begin
        if (cnt_q == WaitLast) begin
          state_d   = ADP_REL;
          cnt_clr   = 1'b1;
          ns_rstn_d = en_q;
        end
      end
      ADP_REL: begin
        if ((fs_rstn & en_q) == en_q) begin
          state_d  = MAC_RDY;
          cnt_clr  = 1'b1;
          ns_mac_d = en_q;
        end else if (cnt_q == TimeoutLast) begin
          state_d = ERROR;
          fail_d  = en_q & ~fs_rstn;
        end
      end
      MAC_RDY: begin
        if ((fs_mac & fs_aln & en_q) == en_q) begin
          state_d = DONE;
        end else if (cnt_q == TimeoutLast) begin
          state_d = ERROR;
          fail_d  = en_q & ~(fs_mac & fs_aln);
        end
      end
      DONE: begin
        if ((en_q & ~(fs_rstn & fs_mac & fs_aln)) != '0) begin
          state_d = ERROR;
          fail_d  = en_q & ~(fs_rstn & fs_mac & fs_aln);
        end
      end
      ERROR: ;
      default: state_d = IDLE;
    endcase

    if (start_ok) begin
      en_d      = bus.i_chn_en;
      fail_d    = '0;
      ns_rstn_d = '0;
      ns_mac_d  = '0;
      cnt_clr   = 1'b1;
      state_d   = (bus.i_chn_en == '0) ? ERROR : RST_WAIT;
    end

    conf_done_d = (state_d == DONE);
    error_d     = (state_d == ERROR);
    busy_d      = (state_d == RST_WAIT) || (state_d == ADP_REL) || (state_d == MAC_RDY);
  end

  // FSM state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Shared phase counter: cleared on phase entry, saturates instead of wrapping
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)             cnt_q <= '0;
    else if (cnt_clr)         cnt_q <= '0;
    else if (cnt_q != CntMax) cnt_q <= cnt_q + CntW'(1);
  end

  // Registered enable mask and outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q        <= '0;
      ns_rstn_q   <= '0;
      ns_mac_q    <= '0;
      fail_q      <= '0;
      conf_done_q <= 1'b0;
      error_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      en_q        <= en_d;
      ns_rstn_q   <= ns_rstn_d;
      ns_mac_q    <= ns_mac_d;
      fail_q      <= fail_d;
      conf_done_q <= conf_done_d;
      error_q     <= error_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.o_ns_adapter_rstn = ns_rstn_q;
  assign bus.o_ns_mac_rdy      = ns_mac_q;
  assign bus.o_fail_mask       = fail_q;
  assign bus.o_conf_done       = conf_done_q;
  assign bus.o_error           = error_q;
  assign bus.o_busy            = busy_q;
  assign bus.o_state           = state_q;

endmodule

// File: doc/aib_link_seq.md
# aib_link_seq

Per-channel AIB link bring-up sequencer. It drives each channel's near-side adapter reset and MAC-ready controls, and waits for the far side to respond and for word alignment. It flags configuration done, or reports which channels failed. It sits on the bus clock domain between the register block and the AIB channel array, and replaces the software-sequenced `c_ns_adapter_rstn` / `c_ns_mac_rdy` writes. Its `o_conf_done` feeds the open-drain conf_done pad.

## Interface
Parameters:
- `NumChannels`, default 6: number of AIB channels sequenced.
- `WaitCycles`, default 64: cycles near-side adapter reset is held low after start; must be ≥1.
- `TimeoutCycles`, default 4096: maximum wait per handshake phase; must be ≥2.

Ports. One clock; reset is asynchronous and active-low.
- `i_clk` input 1: bus clock.
- `i_rst_n` input 1: asynchronous active-low reset.
- `i_start` input 1: single-cycle start/restart request.
- `i_chn_en` input NumChannels: channel enable mask, sampled on accepted start.
- `i_fs_adapter_rstn` input NumChannels: far-side adapter out of reset.
- `i_fs_mac_rdy` input NumChannels: far-side MAC ready.
- `i_word_aligned` input NumChannels: receive word alignment achieved.
- `o_ns_adapter_rstn` output NumChannels: near-side adapter reset release.
- `o_ns_mac_rdy` output NumChannels: near-side MAC ready.
- `o_conf_done` output 1: all enabled channels up.
- `o_busy` output 1: sequence in progress.
- `o_error` output 1: sequence failed or link dropped.
- `o_fail_mask` output NumChannels: channels that caused the error.
- `o_state` output 3: current FSM state encoding, for status readback.

## Operation
- States and encodings:
  - IDLE=0, RST_WAIT=1, ADP_REL=2, MAC_RDY=3, DONE=4, ERROR=5.
- Reset values:
  - All outputs are 0. State is IDLE and the enable register is 0.
- Start acceptance:
  - `i_start` is accepted only in IDLE, DONE or ERROR; it is ignored in the other states.
  - On acceptance: `en` ← `i_chn_en`, `o_fail_mask` ← 0, `o_error` ← 0, `o_conf_done` ← 0, all `o_ns_*` ← 0.
  - If `en`==0, the next state is ERROR with fail_mask 0. Otherwise the next state is RST_WAIT.
- RST_WAIT:
  - Hold `o_ns_adapter_rstn`=0 for WaitCycles cycles, then go to ADP_REL.
- ADP_REL:
  - `o_ns_adapter_rstn` = `en`.
  - Wait until (fs_adapter_rstn & en) == en, then go to MAC_RDY.
- MAC_RDY:
  - `o_ns_mac_rdy` = `en`.
  - Wait until ((fs_mac_rdy & word_aligned) & en) == en, then go to DONE.
- DONE:
  - `o_conf_done`=1.
  - If any enabled channel deasserts fs_adapter_rstn, fs_mac_rdy or word_aligned, go to ERROR. `o_fail_mask` = en & ~(fs_adapter_rstn & fs_mac_rdy & word_aligned).
- ERROR:
  - `o_error`=1 and `o_conf_done`=0.
  - `o_ns_*` hold their last values. Wait for `i_start`.
- Disabled channels keep `o_ns_adapter_rstn` and `o_ns_mac_rdy` at 0 in every state.
- Timeout:
  - One shared counter is cleared on entry to RST_WAIT, ADP_REL and MAC_RDY.
  - In ADP_REL or MAC_RDY: if the exit condition is false in the cycle the counter equals TimeoutCycles-1, go to ERROR.
  - On ADP_REL timeout, `o_fail_mask` = en & ~fs_adapter_rstn. On MAC_RDY timeout, `o_fail_mask` = en & ~(fs_mac_rdy & word_aligned).
  - If the condition is met in that same cycle, the condition wins.
- Counter width: $clog2(max(WaitCycles,TimeoutCycles))+1; the counter saturates and never wraps.
- `o_busy`=1 in RST_WAIT, ADP_REL and MAC_RDY.
- Reset mid-operation: all outputs drop to their reset values asynchronously; no sequence state is retained.

## Timing
- All outputs are registered.
- Cycle numbering: start accepted on edge 0.
- After edge 0: `o_busy`=1 and `o_state`=1.
- After edge WaitCycles: `o_ns_adapter_rstn`=en.
- Far-side inputs are used after the optional synchronizer (2 cycles, see Configuration).
- A phase condition true at the sampling edge k drives the next state's outputs visible after edge k.
- Link-drop detection in DONE has the synchronizer latency plus 1 cycle.
- Restart from DONE or ERROR: outputs clear on the accepting edge, with no idle cycle.

## Configuration
- `AIB_LINK_SEQ_SYNC_EN` defined:
  - `i_fs_adapter_rstn`, `i_fs_mac_rdy` and `i_word_aligned` each pass through a 2-flop synchronizer that resets to 0.
  - Adds 2 cycles of input latency.
- Not defined:
  - Inputs are used combinationally. For a same-clock far side only.

## Test plan
All scenarios run with `AIB_LINK_SEQ_SYNC_EN` defined, WaitCycles=64, TimeoutCycles=4096.

- **Nominal bring-up.** en=6'h3F; fs_adapter_rstn returns 10 cycles after ns release; mac_rdy and aligned return 20 cycles after ns_mac_rdy.
  - Required: ns_adapter_rstn=3F after edge 64, then ns_mac_rdy=3F, then conf_done=1, error=0, busy=0, state=4.
- **Timeout.** en=6'h0F; channel 2 never raises fs_mac_rdy.
  - Required: ERROR exactly 4096 cycles after MAC_RDY entry; fail_mask=6'h04; conf_done=0.
- **Partial mask.** en=6'h21.
  - Required: ns_adapter_rstn and ns_mac_rdy equal 6'h21 and never set bits 1–4; done reached with other channels' fs inputs held at 0.
- **Link drop.** In DONE, deassert word_aligned[5].
  - Required: error=1 and fail_mask=6'h20 within 3 cycles; conf_done=0.
- **Start during busy.** Pulse i_start during RST_WAIT.
  - Required: ignored, and `en` unchanged.
- **Restart and reset.** i_start in ERROR with en=0.
  - Required: ERROR, fail_mask=0.
- **Reset mid-operation.** Assert i_rst_n low in MAC_RDY.
  - Required: all outputs 0 immediately; state=0.
